// File: rtl/lcd_ctrl_param_if.sv
// Host command and IROM/IRAM bus bundle for the LCD controller.
// Modport slave is the controller side, master is the host/memory side.
interface lcd_ctrl_param_if #(
    parameter int DW  = 8,
    parameter int DIM = 8
);
    localparam int AW = $clog2(DIM * DIM);

    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] IROM_Q;
    logic          IROM_rd;
    logic [AW-1:0] IROM_A;
    logic          IRAM_valid;
    logic [DW-1:0] IRAM_D;
    logic [AW-1:0] IRAM_A;
    logic          busy;
    logic          done;

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
    );

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
    );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads a DIMxDIM image from IROM,
// applies 2x2 window commands around an operation point, streams to IRAM.
module lcd_ctrl_param #(
    parameter int DW  = 8,
    parameter int DIM = 8
) (
    input logic clk,
    input logic reset,
    lcd_ctrl_param_if.slave bus
);
    localparam int AW = $clog2(DIM * DIM);
    localparam int LW = $clog2(DIM);
    localparam int N  = DIM * DIM;

    typedef enum logic [1:0] {LOAD, IDLE, EXEC, WRITE} state_t;

    state_t state, state_nx;

    logic [DW-1:0] mem [N];
    logic [3:0]    op;
    logic [LW-1:0] px, py, pxm, pym;
    logic [AW:0]   wcnt;
    logic [AW-1:0] ia, ib, ic, id;
    logic [DW-1:0] a, b, c, d;
    logic [DW-1:0] na, nb, nc, nd;
    logic [DW-1:0] mab, mcd, mx, nab, ncd, mn, avg;
    logic [DW+1:0] sum;
    logic          upd;
    logic          accept;

    assign accept = (state == IDLE) && bus.cmd_valid && !bus.busy;

    // Pixel address is {row, column} because DIM is a power of two
    assign pxm = px - LW'(1);
    assign pym = py - LW'(1);
    assign ia  = {pym, pxm};
    assign ib  = {pym, px};
    assign ic  = {py, pxm};
    assign id  = {py, px};

    assign a = mem[ia];
    assign b = mem[ib];
    assign c = mem[ic];
    assign d = mem[id];

    assign mab = (a > b) ? a : b;
    assign mcd = (c > d) ? c : d;
    assign mx  = (mab > mcd) ? mab : mcd;
    assign nab = (a < b) ? a : b;
    assign ncd = (c < d) ? c : d;
    assign mn  = (nab < ncd) ? nab : ncd;
    assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    assign avg = DW'(sum >> 2);

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (bus.IROM_A == AW'(N - 1)) state_nx = IDLE;
            IDLE:  if (accept) state_nx = (bus.cmd == 4'h0) ? WRITE : EXEC;
            EXEC:  state_nx = IDLE;
            WRITE: if (wcnt == (AW+1)'(N)) state_nx = IDLE;
        endcase
    end

    always_comb begin
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        upd = 1'b0;
        if (state == EXEC) begin
            case (op)
                4'h5: begin upd = 1'b1; na = mx;  nb = mx;  nc = mx;  nd = mx;  end
                4'h6: begin upd = 1'b1; na = mn;  nb = mn;  nc = mn;  nd = mn;  end
                4'h7: begin upd = 1'b1; na = avg; nb = avg; nc = avg; nd = avg; end
                4'h8: begin upd = 1'b1; na = b;   nb = d;   nd = c;   nc = a;   end
                4'h9: begin upd = 1'b1; na = c;   nb = a;   nd = b;   nc = d;   end
                4'hA: begin upd = 1'b1; na = c;   nc = a;   nb = d;   nd = b;   end
                4'hB: begin upd = 1'b1; na = b;   nb = a;   nc = d;   nd = c;   end
                default: upd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    // Image buffer has no reset; a reload always follows reset release
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            mem[bus.IROM_A] <= bus.IROM_Q;
        end else if (upd) begin
            mem[ia] <= na;
            mem[ib] <= nb;
            mem[ic] <= nc;
            mem[id] <= nd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.busy       <= 1'b1;
            bus.IROM_rd    <= 1'b1;
            bus.IROM_A     <= '0;
            bus.IRAM_valid <= 1'b0;
            bus.IRAM_D     <= '0;
            bus.IRAM_A     <= '0;
            bus.done       <= 1'b0;
            px             <= LW'(DIM / 2);
            py             <= LW'(DIM / 2);
            op             <= 4'h0;
            wcnt           <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (bus.IROM_A == AW'(N - 1)) begin
                        bus.IROM_rd <= 1'b0;
                        bus.busy    <= 1'b0;
                    end else begin
                        bus.IROM_A <= bus.IROM_A + AW'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        op       <= bus.cmd;
                        bus.busy <= 1'b1;
                        wcnt     <= '0;
                    end
                end
                EXEC: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    case (op)
                        4'h1: if (py > LW'(1)) py <= pym;
                        4'h2: if (py < LW'(DIM - 1)) py <= py + LW'(1);
                        4'h3: if (px > LW'(1)) px <= pxm;
                        4'h4: if (px < LW'(DIM - 1)) px <= px + LW'(1);
                        default: ;
                    endcase
                end
                WRITE: begin
                    if (wcnt == (AW+1)'(N)) begin
                        bus.IRAM_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                    end else begin
                        bus.IRAM_valid <= 1'b1;
                        bus.IRAM_A     <= wcnt[AW-1:0];
                        bus.IRAM_D     <= mem[wcnt[AW-1:0]];
                        wcnt           <= wcnt + (AW+1)'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed scoreboard bench for lcd_ctrl_param (DW=8, DIM=8):
// load, shifts with clamping, window ops, write streaming, mid-write reset.
module tb_lcd_ctrl_param;
    localparam int DW  = 8;
    localparam int DIM = 8;
    localparam int N   = DIM * DIM;

    typedef struct {
        int a;
        int d;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    lcd_ctrl_param_if #(.DW(DW), .DIM(DIM)) bus ();

    lcd_ctrl_param #(.DW(DW), .DIM(DIM)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [N];
    int            img [N];
    int            mx, my;
    exp_t          sb [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    // ROM data follows the address presented during the preceding half cycle
    always @(negedge clk) if (bus.IROM_rd) bus.IROM_Q <= rom[bus.IROM_A];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_rom_rd"}, 32'(bus.IROM_rd), 1);
        chk({tag, "_rom_a"}, 32'(bus.IROM_A), 0);
        chk({tag, "_ram_v"}, 32'(bus.IRAM_valid), 0);
        chk({tag, "_ram_d"}, 32'(bus.IRAM_D), 0);
        chk({tag, "_ram_a"}, 32'(bus.IRAM_A), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic do_reset();
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 4'h0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        for (int k = 0; k < N; k++) img[k] = int'(rom[k]);
        mx    = DIM / 2;
        my    = DIM / 2;
        sb.delete();
        reset = 1'b1;
        cnt   = 0;
        while (bus.busy && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            chk("load_no_done", 32'(bus.done), 0);
        end
        chk("load_edges", 32'(cnt), N);
        chk("load_rom_rd", 32'(bus.IROM_rd), 0);
    endtask

    function automatic void model(input logic [3:0] c);
        int ia, ib, ic, id, va, vb, vc, vd, r;
        ia = (my - 1) * DIM + (mx - 1);
        ib = ia + 1;
        ic = ia + DIM;
        id = ic + 1;
        va = img[ia]; vb = img[ib]; vc = img[ic]; vd = img[id];
        case (c)
            4'h1: if (my > 1) my--;
            4'h2: if (my < DIM - 1) my++;
            4'h3: if (mx > 1) mx--;
            4'h4: if (mx < DIM - 1) mx++;
            4'h5, 4'h6, 4'h7: begin
                if (c == 4'h7) r = (va + vb + vc + vd) / 4;
                else begin
                    r = va;
                    foreach (img[k]) begin
                        if (k == ib || k == ic || k == id) begin
                            if (c == 4'h5 && img[k] > r) r = img[k];
                            if (c == 4'h6 && img[k] < r) r = img[k];
                        end
                    end
                end
                img[ia] = r; img[ib] = r; img[ic] = r; img[id] = r;
            end
            4'h8: begin img[ia] = vb; img[ib] = vd; img[id] = vc; img[ic] = va; end
            4'h9: begin img[ia] = vc; img[ib] = va; img[id] = vb; img[ic] = vd; end
            4'hA: begin img[ia] = vc; img[ic] = va; img[ib] = vd; img[id] = vb; end
            4'hB: begin img[ia] = vb; img[ib] = va; img[ic] = vd; img[id] = vc; end
            default: ;
        endcase
    endfunction

    task automatic run_cmd(input logic [3:0] c, input bit ghost);
        int   cyc, strobes;
        bit   seen;
        exp_t e;
        if (c == 4'h0)
            for (int k = 0; k < N; k++) sb.push_back('{a: k, d: img[k]});
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("accept_busy", 32'(bus.busy), 1);
        if (ghost) begin
            bus.cmd       = 4'h5;
            bus.cmd_valid = 1'b1;
        end
        seen    = 1'b0;
        cyc     = 0;
        strobes = 0;
        while (!seen && cyc < N + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.cmd_valid = 1'b0;
            if (bus.IRAM_valid) begin
                strobes++;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("iram_a", 32'(bus.IRAM_A), 32'(e.a));
                    chk("iram_d", 32'(bus.IRAM_D), 32'(e.d));
                end
            end
            if (bus.done) begin
                seen = 1'b1;
                chk("done_busy", 32'(bus.busy), 0);
                chk("done_ram_v", 32'(bus.IRAM_valid), 0);
                if (c == 4'h0) chk("ram_a_hold", 32'(bus.IRAM_A), N - 1);
            end
        end
        chk("done_seen", 32'(seen), 1);
        chk("done_latency", 32'(cyc), (c == 4'h0) ? N + 1 : 1);
        chk("strobes", 32'(strobes), (c == 4'h0) ? N : 0);
        chk("sb_left", 32'(sb.size()), 0);
        @(posedge clk);
        #1;
        chk("done_width", 32'(bus.done), 0);
        model(c);
    endtask

    task automatic write_reset(input int at);
        int strobes, cyc;
        @(negedge clk);
        bus.cmd       = 4'h0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        strobes = 0;
        cyc     = 0;
        while (strobes < at && cyc < N + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.IRAM_valid) strobes++;
        end
        chk("wr_reached", 32'(strobes), 32'(at));
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
    endtask

    initial begin
        bus.cmd       = 4'h0;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < N; k++) rom[k] = DW'(k);

        do_reset();
        run_cmd(4'h0, 1'b0);
        run_cmd(4'h5, 1'b0);
        run_cmd(4'h0, 1'b0);
        repeat (5) run_cmd(4'h1, 1'b0);
        repeat (5) run_cmd(4'h3, 1'b0);
        run_cmd(4'h7, 1'b0);
        run_cmd(4'h0, 1'b0);

        do_reset();
        run_cmd(4'h9, 1'b0);
        run_cmd(4'h0, 1'b0);
        do_reset();
        run_cmd(4'hB, 1'b0);
        run_cmd(4'h0, 1'b0);

        rom[27] = 8'd255; rom[28] = 8'd255; rom[35] = 8'd255; rom[36] = 8'd255;
        do_reset();
        run_cmd(4'h7, 1'b0);
        run_cmd(4'h0, 1'b0);

        rom[27] = 8'd3; rom[28] = 8'd9; rom[35] = 8'd1; rom[36] = 8'd7;
        do_reset();
        run_cmd(4'h6, 1'b0);
        run_cmd(4'h0, 1'b0);
        do_reset();
        run_cmd(4'h8, 1'b1);
        run_cmd(4'hA, 1'b0);
        run_cmd(4'hC, 1'b1);
        repeat (5) run_cmd(4'h4, 1'b0);
        repeat (5) run_cmd(4'h2, 1'b0);
        run_cmd(4'h5, 1'b0);
        run_cmd(4'h0, 1'b0);

        for (int k = 0; k < N; k++) rom[k] = DW'(k);
        do_reset();
        run_cmd(4'h0, 1'b1);
        write_reset(20);
        do_reset();
        run_cmd(4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised image-processing controller for the LCD path, built as the next generation of the fixed 8x8, 8-bit controller. After reset it loads a DIMxDIM image from IROM into an internal buffer. It then executes host commands on a 2x2 window around an operation point: shift, max, min, average, rotate and mirror. A write command streams the whole buffer to IRAM.

Parameters:
DW, 8, pixel width in bits (>=2).
DIM, 8, image edge length; power of 2, >=4.
AW, log2(DIM*DIM), derived localparam, pixel address width; not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd  in  4  command code.
cmd_valid  in  1  command strobe.
IROM_Q  in  DW  ROM read data; valid one cycle after IROM_A/IROM_rd (registered ROM).
IROM_rd  out  1  ROM read enable.
IROM_A  out  AW  ROM address.
IRAM_valid  out  1  RAM write strobe.
IRAM_D  out  DW  RAM write data.
IRAM_A  out  AW  RAM write address.
busy  out  1  high = commands ignored.
done  out  1  one-cycle pulse on command completion.

Behaviour:
Reset values:
- busy=1, IROM_rd=1, IROM_A=0.
- IRAM_valid=0, IRAM_D=0, IRAM_A=0, done=0.
- Operation point (x,y)=(DIM/2,DIM/2). Buffer contents are undefined.

Addressing:
- Pixel address = y*DIM+x; x = column, y = row.
- Window: a=(x-1,y-1), b=(x,y-1), c=(x-1,y), d=(x,y).
- x and y each range 1..DIM-1.

States: LOAD, IDLE, EXEC, WRITE.

LOAD:
- Entered on reset release.
- Edge k=1..N-1 (N=DIM*DIM): IROM_A=k, buf[k-1]<=IROM_Q.
- Edge N: buf[N-1]<=IROM_Q, IROM_rd<=0, busy<=0, go to IDLE. No done pulse.

IDLE:
- Command accepted on an edge where cmd_valid=1 and busy=0.
- On acceptance: latch cmd, busy<=1, go to EXEC or WRITE.
- cmd_valid while busy=1 is ignored; the command is not queued.

EXEC (cmd != 0): one cycle. At the next edge apply the command, busy<=0, done<=1, go to IDLE.
- 1 up: y-1. 2 down: y+1. 3 left: x-1. 4 right: x+1. Shifts clamp at 1 and DIM-1; a clamped shift still completes with a done pulse.
- 5 max, 6 min: all four window pixels <= max / min of a,b,c,d.
- 7 average: all four pixels <= floor((a+b+c+d)/4). Sum held in DW+2 bits, no overflow.
- 8 rotate CCW: a<=b, b<=d, d<=c, c<=a.
- 9 rotate CW: a<=c, b<=a, d<=b, c<=d.
- A mirror X (about horizontal axis): swap a<->c and b<->d.
- B mirror Y (about vertical axis): swap a<->b and c<->d.
- C-F reserved: no operation; still busy for one cycle, then done.

WRITE (cmd 0):
- Edges 1..N after acceptance: IRAM_valid=1, IRAM_A=k, IRAM_D=buf[k], for k=0..N-1.
- Edge N+1: IRAM_valid<=0, busy<=0, done<=1.
- The buffer is unchanged; IRAM_A holds N-1 afterwards.

Completion handshake:
- done is high for exactly one cycle, and busy=0 in that cycle.
- A new command may be accepted on the edge that ends the done cycle; done then clears as normal.

Reset mid-operation:
- Any state, including mid-LOAD and mid-WRITE: outputs return to reset values immediately.
- The full image is reloaded after release.

Test Plan:
1. DIM=8, ROM pixel k=k, reset released → busy falls after 64 edges. Write cmd → 64 strobes, IRAM_A 0..63 with IRAM_D=IRAM_A, then a one-cycle done pulse.
2. After load, max (cmd 5) then write → addresses 27, 28, 35, 36 read 36; all other addresses unchanged.
3. Up ×5 then left ×5 → point clamps at (1,1). Average then write → addresses 0, 1, 8, 9 read floor(18/4)=4. Each shift gives one done pulse.
4. At point (4,4): rotate CW → 27=35, 28=27, 36=28, 35=36. Mirror Y on the original image → 27↔28 and 35↔36 swapped.
5. DW=8 with all window pixels 255, average → result 255 (no overflow). min on window {3,9,1,7} → all four pixels = 1.
6. cmd_valid pulsed while busy, and reset asserted at WRITE cycle 20 → no extra command executes; IRAM_valid=0 immediately on reset; image reloads and a later write streams the original data.
